// File: rtl/laser_frame_receiver_if.sv
// Bundles the receiver's line input, enable and byte/strobe outputs.
// The master side is the receiver itself; the slave side is whoever drives
// the photodiode line and consumes the recovered bytes.
interface laser_frame_receiver_if;
   logic       en;
   logic       laser_in;
   logic       data_valid;
   logic [7:0] data_in;
   logic       frame_err;
   logic       busy;
   logic [7:0] err_count;

   modport master (
      input  en,
      input  laser_in,
      output data_valid,
      output data_in,
      output frame_err,
      output busy,
      output err_count
   );

   modport slave (
      output en,
      output laser_in,
      input  data_valid,
      input  data_in,
      input  frame_err,
      input  busy,
      input  err_count
   );
endinterface

// File: rtl/laser_frame_receiver.sv
// Byte receiver for the single-bit laser link: start bit high, 8 data bits
// LSB first, stop bit low. The line is synchronized, each bit is decided by a
// 3-sample majority vote near mid-bit, false starts are dropped and bad stop
// bits are flagged and counted.
module laser_frame_receiver #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SYNC_STAGES  = 2
) (
   input logic                    clock,
   input logic                    reset,
   laser_frame_receiver_if.master bus
);

   localparam int             CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   line;
   logic                   line_d1;
   logic                   line_d2;
   logic                   vote;

   state_t      state;
   state_t      state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [2:0]  bit_idx;
   logic [2:0]  bit_nx;
   logic [7:0]  shreg;
   logic [7:0]  shreg_nx;
   logic        good;
   logic        bad;

   assign line     = sync[SYNC_STAGES-1];
   assign vote     = (line & line_d1) | (line & line_d2) | (line_d1 & line_d2);
   assign bus.busy = (state != IDLE);

   // Synchronizer and vote history; keeps running while disabled so a line
   // that is already high at re-enable is not seen as a fresh edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync    <= '0;
         line_d1 <= 1'b0;
         line_d2 <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], bus.laser_in};
         line_d1 <= line;
         line_d2 <= line_d1;
      end
   end

   // Next-state logic: bit timing, sampling, frame decision and enable abort.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      bit_nx   = bit_idx;
      shreg_nx = shreg;
      good     = 1'b0;
      bad      = 1'b0;
      case (state)
         IDLE: begin
            if (line && !line_d1) begin
               state_nx = START;
               cnt_nx   = '0;
            end
         end
         START: begin
            if (cnt == HALF) begin
               cnt_nx = '0;
               if (vote) begin
                  state_nx = DATA;
                  bit_nx   = 3'd0;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == LAST) begin
               cnt_nx   = '0;
               shreg_nx = {vote, shreg[7:1]};
               if (bit_idx == 3'd7) state_nx = STOP;
               else                 bit_nx   = bit_idx + 3'd1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == LAST) begin
               cnt_nx = '0;
               if (!vote) begin
                  good     = 1'b1;
                  state_nx = IDLE;
               end else begin
                  bad      = 1'b1;
                  state_nx = BREAK;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         BREAK: begin
            // A stuck-high line must go low before another start is accepted.
            if (!line) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (!bus.en) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         bit_nx   = 3'd0;
         shreg_nx = 8'd0;
         good     = 1'b0;
         bad      = 1'b0;
      end
   end

   // State register, strobes, held byte and saturating error counter.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         bit_idx        <= 3'd0;
         shreg          <= 8'd0;
         bus.data_valid <= 1'b0;
         bus.data_in    <= 8'd0;
         bus.frame_err  <= 1'b0;
         bus.err_count  <= 8'd0;
      end else begin
         state          <= state_nx;
         cnt            <= cnt_nx;
         bit_idx        <= bit_nx;
         shreg          <= shreg_nx;
         bus.data_valid <= good;
         bus.frame_err  <= bad;
         if (good) bus.data_in <= shreg;
         if (bad && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_laser_frame_receiver.sv
// Testbench for laser_frame_receiver: directed frames from the behaviour list
// followed by randomized traffic, compared against a frame-level model.
module tb_laser_frame_receiver;

   localparam int C   = 8;
   localparam int S   = 2;
   localparam int LAT = S + C / 2 + 9 * C;

   logic clock = 1'b0;
   logic reset = 1'b0;

   laser_frame_receiver_if bus_if();

   laser_frame_receiver #(.CLKS_PER_BIT(C), .SYNC_STAGES(S)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] b;
      logic       err;
   } ev_t;

   ev_t ev_q[$];
   ev_t exp_q[$];

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_data = 8'd0;
   logic [7:0] model_err  = 8'd0;

   // Observed strobes, logged on the falling edge with their cycle stamp.
   always @(negedge clock) begin
      if (bus_if.data_valid === 1'b1) ev_q.push_back(ev_t'{cyc, bus_if.data_in, 1'b0});
      if (bus_if.frame_err === 1'b1)  ev_q.push_back(ev_t'{cyc, bus_if.data_in, 1'b1});
   end

   initial begin
      #900000;
      $display("FAIL timeout: observed no finish, expected finish within budget");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      bus_if.laser_in = v;
      repeat (n) @(negedge clock);
   endtask

   task automatic drive_bit(input logic v, input bit spike);
      for (int i = 0; i < C; i++) begin
         bus_if.laser_in = (spike && i == C / 2 - 1) ? ~v : v;
         @(negedge clock);
      end
   endtask

   // stop_high = 0: proper low stop bit; otherwise stop held high that many bit times.
   task automatic send_frame(input logic [7:0] b, input int stop_high, input bit spike);
      int st;
      st = cyc;
      drive_bit(1'b1, 1'b0);
      for (int k = 0; k < 8; k++) drive_bit(b[k], spike);
      if (stop_high == 0) begin
         drive_bit(1'b0, 1'b0);
         exp_q.push_back(ev_t'{st + 1 + LAT, b, 1'b0});
         model_data = b;
      end else begin
         repeat (stop_high) drive_bit(1'b1, 1'b0);
         bus_if.laser_in = 1'b0;
         exp_q.push_back(ev_t'{st + 1 + LAT, model_data, 1'b1});
         if (model_err != 8'hFF) model_err = model_err + 8'd1;
      end
   endtask

   task automatic check_events(input string tag);
      ev_t e;
      ev_t a;
      chk({tag, " strobe count"}, ev_q.size(), exp_q.size());
      while (exp_q.size() > 0 && ev_q.size() > 0) begin
         e = exp_q.pop_front();
         a = ev_q.pop_front();
         chk({tag, " strobe cycle"}, a.cyc, e.cyc);
         chk({tag, " strobe byte"}, a.b, e.b);
         chk({tag, " strobe kind"}, a.err, e.err);
      end
      exp_q.delete();
      ev_q.delete();
      chk({tag, " data_in"}, bus_if.data_in, model_data);
      chk({tag, " err_count"}, bus_if.err_count, model_err);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " data_valid"}, bus_if.data_valid, 0);
      chk({tag, " data_in"}, bus_if.data_in, 0);
      chk({tag, " frame_err"}, bus_if.frame_err, 0);
      chk({tag, " busy"}, bus_if.busy, 0);
      chk({tag, " err_count"}, bus_if.err_count, 0);
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] rb;
      bit         seen;
      int         kind;

      bus_if.en       = 1'b1;
      bus_if.laser_in = 1'b0;
      reset           = 1'b0;
      repeat (4) @(negedge clock);
      check_zero("reset");
      reset = 1'b1;
      hold(1'b0, 2 * C);

      send_frame(8'hA5, 0, 1'b0);
      hold(1'b0, C);
      check_events("a5");

      send_frame(8'h00, 0, 1'b0);
      send_frame(8'hFF, 0, 1'b0);
      hold(1'b0, C);
      check_events("b2b");

      hold(1'b1, 2);
      bus_if.laser_in = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2 * C; i++) begin
         if (bus_if.busy === 1'b1) seen = 1'b1;
         @(negedge clock);
      end
      chk("glitch busy seen", seen, 1);
      chk("glitch busy after", bus_if.busy, 0);
      check_events("glitch");

      send_frame(8'h3C, 3, 1'b0);
      hold(1'b0, C);
      check_events("stop err");
      send_frame(8'h11, 0, 1'b0);
      hold(1'b0, C);
      check_events("after err");

      send_frame(8'h5A, 0, 1'b1);
      hold(1'b0, C);
      check_events("spike");

      pat = 8'h77;
      drive_bit(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) drive_bit(pat[k], 1'b0);
      hold(pat[4], 2);
      chk("mid frame busy", bus_if.busy, 1);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_zero("mid reset");
      hold(1'b0, C);
      reset      = 1'b1;
      model_data = 8'd0;
      model_err  = 8'd0;
      hold(1'b0, 2 * C);
      send_frame(8'h42, 0, 1'b0);
      hold(1'b0, C);
      check_events("post reset");

      drive_bit(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) drive_bit(pat[k], 1'b0);
      hold(pat[4], 2);
      bus_if.en = 1'b0;
      repeat (2) @(negedge clock);
      chk("disabled busy", bus_if.busy, 0);
      hold(1'b1, 2 * C);
      chk("disabled high busy", bus_if.busy, 0);
      check_events("disabled");
      bus_if.en = 1'b1;
      hold(1'b1, 2 * C);
      chk("reenable high busy", bus_if.busy, 0);
      hold(1'b0, 2 * C);
      send_frame(8'hC3, 0, 1'b0);
      hold(1'b0, C);
      check_events("post enable");

      for (int n = 0; n < 30; n++) begin
         kind = int'($urandom_range(0, 9));
         rb   = 8'($urandom);
         if (kind == 0) begin
            hold(1'b1, int'($urandom_range(1, 2)));
            hold(1'b0, 2 * C + int'($urandom_range(0, C)));
         end else if (kind == 1) begin
            send_frame(rb, 1, 1'b0);
            hold(1'b0, C + int'($urandom_range(0, C)));
         end else begin
            send_frame(rb, 0, 1'($urandom_range(0, 1)));
            hold(1'b0, int'($urandom_range(0, 2 * C)));
         end
         check_events("random");
      end

      while (model_err != 8'hFF) begin
         send_frame(8'($urandom), 1, 1'b0);
         hold(1'b0, C);
         check_events("sat ramp");
      end
      send_frame(8'($urandom), 1, 1'b0);
      hold(1'b0, C);
      check_events("sat hold");
      send_frame(8'h96, 0, 1'b0);
      hold(1'b0, C);
      check_events("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
